// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU results against queued load results onto the
// register file's single registered write port, and tracks pending-load hazards.
module writeback_unit #(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        inEn
);

  localparam int              PTR_W      = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [PTR_W:0]  LQ_FULL    = (PTR_W + 1)'(LQ_DEPTH);
  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LD
  } grant_e;

  logic [4:0]       lq_rd_q   [LQ_DEPTH];
  logic [4:0]       lq_rd_d   [LQ_DEPTH];
  logic [31:0]      lq_data_q [LQ_DEPTH];
  logic [31:0]      lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic [4:0]       writereg_q, writereg_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             in_en_q, in_en_d;

  grant_e      grant;
  logic        lq_empty, lq_full, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign lq_empty  = (count_q == '0);
  assign lq_full   = (count_q == LQ_FULL);
  assign head_rd   = lq_rd_q[rd_ptr_q];
  assign head_data = lq_data_q[rd_ptr_q];

  // Loads win when the ALU is idle or has starved the queue head long enough.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (!lq_empty && (!alu_valid || starve_cnt_q == STARVE_MAX)) grant = GNT_LD;
      else if (alu_valid)                                           grant = GNT_ALU;
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign ld_ready  = reset || !lq_full;
  assign push      = ld_valid && !lq_full && !reset;
  assign pop       = (grant == GNT_LD);

  assign rs1_busy  = busy_q[chk_rs1];
  assign rs2_busy  = busy_q[chk_rs2];
  assign writereg  = writereg_q;
  assign writedata = writedata_q;
  assign inEn      = in_en_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      lq_rd_d[wr_ptr_q]   = ld_rd;
      lq_data_d[wr_ptr_q] = ld_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || lq_empty)
      starve_cnt_d = '0;
    else if (grant == GNT_ALU && starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Issue is applied after the grant clear so a same-cycle re-issue stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    in_en_d     = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    case (grant)
      GNT_LD: begin
        writereg_d  = head_rd;
        writedata_d = head_data;
        in_en_d     = (head_rd != 5'd0);
      end
      GNT_ALU: begin
        writereg_d  = alu_rd;
        writedata_d = alu_data;
        in_en_d     = (alu_rd != 5'd0);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      busy_q       <= '0;
      writereg_q   <= '0;
      writedata_q  <= '0;
      in_en_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      writereg_q   <= writereg_d;
      writedata_q  <= writedata_d;
      in_en_q      <= in_en_d;
    end
  end

  // NOTE: queue storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    lq_rd_q   <= lq_rd_d;
    lq_data_q <= lq_data_d;
  end

endmodule
